// File: rtl/echo_gate_capture.sv
// echo_gate_capture: trigger-gated, decimated multi-channel echo capture.
// A trigger edge powers the ADC, skips a programmable number of valid beats,
// stores every (decim+1)-th beat into an internal buffer, then drains the
// buffer oldest-first over a valid/ready port.
// Optional feature: define ECHO_PEAK_EN to track the channel-0 peak amplitude
// and its stored-beat index; when undefined o_peak/o_peak_idx are tied to 0.

module echo_gate_capture #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned CNT_W    = 16  // must exceed ADDR_W so the full depth is representable
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_trig,
  input  logic [CNT_W-1:0]             i_delay,
  input  logic [CNT_W-1:0]             i_count,
  input  logic [7:0]                   i_decim,
  input  logic                         i_sample_vld,
  input  logic [DATA_W*CHANNELS-1:0]   i_sample,
  output logic                         o_ad_open,
  output logic                         o_busy,
  output logic                         o_rd_vld,
  input  logic                         i_rd_rdy,
  output logic [DATA_W*CHANNELS-1:0]   o_rd_data,
  output logic                         o_done,
  output logic                         o_clamp,
  output logic                         o_miss,
  output logic [DATA_W-1:0]            o_peak,
  output logic [ADDR_W-1:0]            o_peak_idx
);

  localparam int unsigned BeatW = DATA_W * CHANNELS;
  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(Depth);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StDelay, StCapture, StDrain} state_e;

  state_e             state_q;
  logic               trig_q;
  logic [CNT_W-1:0]   delay_q;
  logic [CNT_W-1:0]   n_q;        // beats to store, already clamped to the buffer depth
  logic [7:0]         decim_q;
  logic [CNT_W-1:0]   dcnt_q;     // valid beats skipped so far
  logic [7:0]         dec_q;      // decimation phase, 0 means store this beat
  logic [CNT_W-1:0]   wr_cnt_q;   // beats stored; low bits are the write pointer
  logic [CNT_W-1:0]   rd_cnt_q;   // beats accepted; low bits address the beat on o_rd_data
  logic               rd_started_q;
  logic               rd_vld_q;
  logic [BeatW-1:0]   rd_data_q;
  logic               ad_open_q;
  logic               busy_q;
  logic               done_q;
  logic               clamp_q;
  logic               miss_q;

  logic [BeatW-1:0]   mem [Depth];

  logic               trig_edge;
  logic               store_en;
  logic               store_last;
  logic               rd_first;
  logic               rd_accept;
  logic               rd_last;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic [CNT_W-1:0]   dcnt_nxt;
  logic [CNT_W-1:0]   wr_cnt_nxt;
  logic [CNT_W-1:0]   rd_cnt_nxt;

  // Decode store/read strobes from the current state and handshake.
  always_comb begin
    trig_edge  = i_trig & ~trig_q;
    dcnt_nxt   = dcnt_q + CntOne;
    wr_cnt_nxt = wr_cnt_q + CntOne;
    rd_cnt_nxt = rd_cnt_q + CntOne;
    store_en   = (state_q == StCapture) && (n_q != '0) && i_sample_vld && (dec_q == '0);
    store_last = store_en && (wr_cnt_nxt == n_q);
    // One idle cycle after DRAIN entry, then the first buffer read is issued.
    rd_first   = (state_q == StDrain) && (n_q != '0) && rd_started_q && !rd_vld_q;
    rd_accept  = (state_q == StDrain) && rd_vld_q && i_rd_rdy;
    rd_last    = rd_accept && (rd_cnt_nxt == n_q);
    // New data is fetched only on acceptance, so o_rd_data holds during a stall.
    rd_en      = rd_first || (rd_accept && !rd_last);
    rd_addr    = rd_first ? '0 : rd_cnt_nxt[ADDR_W-1:0];
  end

  // Capture buffer write port; contents are not reset.
  always_ff @(posedge i_clk) begin
    if (store_en) begin
      mem[wr_cnt_q[ADDR_W-1:0]] <= i_sample;
    end
  end

  // Synchronous buffer read into the output data register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  // Main sequencer with registered status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      trig_q       <= 1'b0;
      delay_q      <= '0;
      n_q          <= '0;
      decim_q      <= '0;
      dcnt_q       <= '0;
      dec_q        <= '0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      rd_started_q <= 1'b0;
      rd_vld_q     <= 1'b0;
      ad_open_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      clamp_q      <= 1'b0;
      miss_q       <= 1'b0;
    end else begin
      trig_q <= i_trig;
      done_q <= 1'b0;
      miss_q <= trig_edge && (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (trig_edge) begin
            delay_q      <= i_delay;
            decim_q      <= i_decim;
            n_q          <= (i_count > DepthCnt) ? DepthCnt : i_count;
            clamp_q      <= (i_count > DepthCnt);
            dcnt_q       <= '0;
            dec_q        <= '0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            rd_started_q <= 1'b0;
            ad_open_q    <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= StDelay;
          end
        end
        StDelay: begin
          // The beat that completes the delay is skipped, so capture starts with the next one.
          if ((delay_q == '0) || (i_sample_vld && (dcnt_nxt == delay_q))) begin
            state_q <= StCapture;
          end else if (i_sample_vld) begin
            dcnt_q <= dcnt_nxt;
          end
        end
        StCapture: begin
          if (n_q == '0) begin
            ad_open_q <= 1'b0;
            state_q   <= StDrain;
          end else if (i_sample_vld) begin
            dec_q <= (dec_q == decim_q) ? '0 : dec_q + 8'd1;
            if (store_en) begin
              wr_cnt_q <= wr_cnt_nxt;
            end
            if (store_last) begin
              ad_open_q <= 1'b0;
              state_q   <= StDrain;
            end
          end
        end
        StDrain: begin
          if (n_q == '0) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else if (!rd_started_q) begin
            rd_started_q <= 1'b1;
          end else if (rd_first) begin
            rd_vld_q <= 1'b1;
          end else if (rd_accept) begin
            if (rd_last) begin
              rd_vld_q <= 1'b0;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= StIdle;
            end else begin
              rd_cnt_q <= rd_cnt_nxt;
            end
          end
        end
      endcase
    end
  end

  assign o_ad_open = ad_open_q;
  assign o_busy    = busy_q;
  assign o_rd_vld  = rd_vld_q;
  assign o_rd_data = rd_data_q;
  assign o_done    = done_q;
  assign o_clamp   = clamp_q;
  assign o_miss    = miss_q;

`ifdef ECHO_PEAK_EN
  logic [DATA_W-1:0] peak_q;
  logic [ADDR_W-1:0] peak_idx_q;
  logic [DATA_W-1:0] ch0;

  assign ch0 = i_sample[DATA_W-1:0];

  // Channel-0 running maximum; strict compare keeps the first index on ties.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      peak_q     <= '0;
      peak_idx_q <= '0;
    end else if ((state_q == StIdle) && trig_edge) begin
      peak_q     <= '0;
      peak_idx_q <= '0;
    end else if (store_en && (ch0 > peak_q)) begin
      peak_q     <= ch0;
      peak_idx_q <= wr_cnt_q[ADDR_W-1:0];
    end
  end

  assign o_peak     = peak_q;
  assign o_peak_idx = peak_idx_q;
`else
  assign o_peak     = '0;
  assign o_peak_idx = '0;
`endif

endmodule

// File: tb/tb_echo_gate_capture.sv
// Self-checking bench for echo_gate_capture: randomized captures compared against a
// beat-list reference model (skip delay beats, keep every (decim+1)-th, clamp to depth).
module tb_echo_gate_capture;
  localparam int DW = 8;
  localparam int CH = 2;
  localparam int AW = 8;
  localparam int CW = 16;
  localparam int BW = DW * CH;
  localparam int DEPTH = 2 ** AW;
  localparam int BUDGET = 5000;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_trig = 1'b0;
  logic [CW-1:0] i_delay = '0;
  logic [CW-1:0] i_count = '0;
  logic [7:0]    i_decim = '0;
  logic          i_sample_vld = 1'b0;
  logic [BW-1:0] i_sample = '0;
  logic          i_rd_rdy = 1'b0;
  logic          o_ad_open, o_busy, o_rd_vld, o_done, o_clamp, o_miss;
  logic [BW-1:0] o_rd_data;
  logic [DW-1:0] o_peak;
  logic [AW-1:0] o_peak_idx;

  echo_gate_capture #(.DATA_W(DW), .CHANNELS(CH), .ADDR_W(AW), .CNT_W(CW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_trig(i_trig), .i_delay(i_delay),
    .i_count(i_count), .i_decim(i_decim), .i_sample_vld(i_sample_vld),
    .i_sample(i_sample), .o_ad_open(o_ad_open), .o_busy(o_busy), .o_rd_vld(o_rd_vld),
    .i_rd_rdy(i_rd_rdy), .o_rd_data(o_rd_data), .o_done(o_done), .o_clamp(o_clamp),
    .o_miss(o_miss), .o_peak(o_peak), .o_peak_idx(o_peak_idx)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Results collected by do_capture, judged by the scenario tasks.
  logic [BW-1:0] beats_q[$];
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] got_q[$];
  logic [DW-1:0] exp_peak;
  int            exp_idx;
  logic          open_before, open_after, end_clamp, end_busy, timeout;
  int            fall_cyc, first_vld, last_acc, done_cyc, done_pulses, miss_pulses, stall_bad;
  logic [DW-1:0] end_peak;
  logic [AW-1:0] end_peak_idx;
  logic [7:0]    pk_list [5] = '{8'd5, 8'd9, 8'd200, 8'd7, 8'd200};

  // Reference: from the valid beats seen after the trigger, drop d, keep every (dec+1)-th.
  task automatic build_expect(input int d, input int cnt, input int dec);
    int n;
    n = (cnt > DEPTH) ? DEPTH : cnt;
    exp_q.delete();
    for (int i = d; i < beats_q.size() && exp_q.size() < n; i++)
      if (((i - d) % (dec + 1)) == 0) exp_q.push_back(beats_q[i]);
    exp_peak = '0;
    exp_idx  = 0;
`ifdef ECHO_PEAK_EN
    foreach (exp_q[i])
      if (exp_q[i][DW-1:0] > exp_peak) begin
        exp_peak = exp_q[i][DW-1:0];
        exp_idx  = i;
      end
`endif
  endtask

  // smode 0: ramp from start every cycle; 1: random vld/data; 2: pk_list then random.
  task automatic do_capture(input int d, input int cnt, input int dec, input int smode,
                            input int start, input int rdy_rand, input int miss_at);
    int cyc, k;
    logic feeding, v, prev_stall;
    logic [BW-1:0] beat, prev_data;
    logic [DW-1:0] c0;
    beats_q.delete(); got_q.delete();
    fall_cyc = -1; first_vld = -1; last_acc = -1; done_cyc = -1;
    done_pulses = 0; miss_pulses = 0; stall_bad = 0; k = 0;
    feeding = 1'b1; prev_stall = 1'b0; prev_data = '0;
    @(posedge i_clk); #1;
    open_before = o_ad_open;
    i_delay = CW'(d); i_count = CW'(cnt); i_decim = 8'(dec); i_trig = 1'b1;
    i_sample_vld = 1'b0;
    @(posedge i_clk); #1;
    open_after = o_ad_open;
    i_trig = 1'b0;
    // Scramble controls: they must only matter at the latch cycle.
    i_delay = CW'($urandom); i_count = CW'($urandom); i_decim = 8'($urandom);
    i_sample_vld = 1'b0;
    cyc = 1;
    while (cyc < BUDGET) begin
      @(posedge i_clk); #1;
      cyc++;
      if (o_done) begin
        done_pulses++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (o_miss) miss_pulses++;
      if (prev_stall && (!o_rd_vld || o_rd_data !== prev_data)) stall_bad++;
      if (feeding && !o_ad_open) begin
        feeding = 1'b0;
        fall_cyc = cyc;
      end
      if (o_rd_vld && first_vld < 0) first_vld = cyc;
      if (feeding) begin
        case (smode)
          0: begin v = 1'b1; c0 = 8'(start + k); beat = {c0 ^ 8'h5A, c0}; end
          1: begin v = ($urandom_range(3, 0) != 0); beat = BW'($urandom); end
          default: begin
            v = 1'b1;
            c0 = (k < 5) ? pk_list[k] : 8'($urandom);
            beat = {8'($urandom), c0};
          end
        endcase
        i_sample_vld = v;
        i_sample = beat;
        if (v) begin beats_q.push_back(beat); k++; end
      end else begin
        i_sample_vld = 1'b0;
      end
      i_rd_rdy = (rdy_rand != 0) ? 1'($urandom) : 1'b1;
      if (o_rd_vld && i_rd_rdy) begin got_q.push_back(o_rd_data); last_acc = cyc; end
      prev_stall = o_rd_vld && !i_rd_rdy;
      prev_data  = o_rd_data;
      i_trig = (miss_at > 0) && (fall_cyc >= 0) && (cyc == fall_cyc + miss_at);
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    timeout = (done_cyc < 0);
    end_clamp = o_clamp; end_busy = o_busy; end_peak = o_peak; end_peak_idx = o_peak_idx;
    i_rd_rdy = 1'b0; i_trig = 1'b0; i_sample_vld = 1'b0;
    build_expect(d, cnt, dec);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge i_clk);
    #1;
    n_cmp++;
    if ({o_ad_open, o_busy, o_rd_vld, o_done, o_clamp, o_miss, o_rd_data, o_peak, o_peak_idx}
        !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got vld=%b busy=%b open=%b data=%h want all 0",
               o_rd_vld, o_busy, o_ad_open, o_rd_data);
    end
    @(negedge i_clk) i_rst_n = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    n_cmp++;
    if ({o_busy, o_ad_open, o_rd_vld} !== 3'b000) begin
      n_err++;
      $display("FAIL idle_after_reset: got busy=%b open=%b vld=%b want 0", o_busy, o_ad_open,
               o_rd_vld);
    end
  endtask

  task automatic test_basic();
    do_capture(3, 4, 0, 0, 0, 0, 0);
    n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL basic_timeout: got 1 want 0"); end
    n_cmp++; if (open_before !== 1'b0) begin n_err++; $display("FAIL basic_open_idle: got %b want 0", open_before); end
    n_cmp++; if (open_after !== 1'b1) begin n_err++; $display("FAIL basic_open_delay: got %b want 1", open_after); end
    n_cmp++; if (got_q.size() != 4) begin n_err++; $display("FAIL basic_len: got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got_q[i][DW-1:0] !== 8'(3 + i) || got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL basic_data[%0d]: got %h want ch0 %0d / %h", i, got_q[i], 3 + i, exp_q[i]);
      end
    end
    n_cmp++; if (first_vld - fall_cyc != 2) begin n_err++; $display("FAIL basic_vld_latency: got %0d want 2", first_vld - fall_cyc); end
    n_cmp++; if (done_cyc - last_acc != 1) begin n_err++; $display("FAIL basic_done_gap: got %0d want 1", done_cyc - last_acc); end
    n_cmp++; if (done_pulses != 1) begin n_err++; $display("FAIL basic_done_pulses: got %0d want 1", done_pulses); end
    n_cmp++; if (end_clamp !== 1'b0 || end_busy !== 1'b0) begin n_err++; $display("FAIL basic_status: got clamp=%b busy=%b want 0 0", end_clamp, end_busy); end
  endtask

  task automatic test_decim();
    do_capture(0, 3, 2, 0, 10, 0, 0);
    n_cmp++; if (got_q.size() != 3 || timeout) begin n_err++; $display("FAIL decim_len: got %0d want 3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (got_q[i][DW-1:0] !== 8'(10 + 3 * i) || got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL decim_data[%0d]: got %h want ch0 %0d / %h", i, got_q[i], 10 + 3 * i, exp_q[i]);
      end
    end
  endtask

  task automatic test_clamp_and_empty();
    int bad;
    do_capture(1, 300, 0, 0, 0, 1, 0);
    n_cmp++; if (got_q.size() != DEPTH || timeout) begin n_err++; $display("FAIL clamp_len: got %0d want %0d", got_q.size(), DEPTH); end
    bad = 0;
    foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) bad++;
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL clamp_data: got %0d wrong beats want 0", bad); end
    n_cmp++; if (end_clamp !== 1'b1) begin n_err++; $display("FAIL clamp_flag: got %b want 1", end_clamp); end
    do_capture(2, 0, 1, 1, 0, 0, 0);
    n_cmp++; if (first_vld >= 0 || got_q.size() != 0) begin n_err++; $display("FAIL empty_no_vld: got first_vld=%0d beats=%0d want none", first_vld, got_q.size()); end
    n_cmp++; if (timeout || done_cyc - fall_cyc != 1) begin n_err++; $display("FAIL empty_done_time: got %0d want 1", done_cyc - fall_cyc); end
    n_cmp++; if (done_pulses != 1 || end_clamp !== 1'b0) begin n_err++; $display("FAIL empty_status: got done=%0d clamp=%b want 1 0", done_pulses, end_clamp); end
  endtask

  task automatic test_stall_miss();
    int d, cnt, dec, bad;
    for (int it = 0; it < 4; it++) begin
      d = $urandom_range(5, 0); cnt = $urandom_range(40, 1); dec = $urandom_range(3, 0);
      do_capture(d, cnt, dec, 1, 0, 1, 2);
      n_cmp++; if (timeout || got_q.size() != exp_q.size()) begin n_err++; $display("FAIL stall_len[%0d]: got %0d want %0d", it, got_q.size(), exp_q.size()); end
      bad = 0;
      foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) bad++;
      n_cmp++; if (bad != 0) begin n_err++; $display("FAIL stall_data[%0d]: got %0d wrong beats want 0", it, bad); end
      n_cmp++; if (stall_bad != 0) begin n_err++; $display("FAIL stall_hold[%0d]: got %0d changes want 0", it, stall_bad); end
      n_cmp++; if (miss_pulses != 1) begin n_err++; $display("FAIL miss_pulse[%0d]: got %0d want 1", it, miss_pulses); end
      n_cmp++; if (done_pulses != 1 || end_busy !== 1'b0) begin n_err++; $display("FAIL no_restart[%0d]: got done=%0d busy=%b want 1 0", it, done_pulses, end_busy); end
      n_cmp++; if (end_peak !== exp_peak || end_peak_idx !== AW'(exp_idx)) begin n_err++; $display("FAIL rand_peak[%0d]: got %0d@%0d want %0d@%0d", it, end_peak, end_peak_idx, exp_peak, exp_idx); end
    end
  endtask

  task automatic test_peak();
    logic [DW-1:0] want_peak;
    logic [AW-1:0] want_idx;
`ifdef ECHO_PEAK_EN
    want_peak = 8'd200; want_idx = 8'd2;
`else
    want_peak = '0; want_idx = '0;
`endif
    do_capture(0, 5, 0, 2, 0, 0, 0);
    n_cmp++; if (got_q.size() != 5 || timeout) begin n_err++; $display("FAIL peak_len: got %0d want 5", got_q.size()); end
    n_cmp++;
    if (end_peak !== want_peak || end_peak_idx !== want_idx) begin
      n_err++;
      $display("FAIL peak_value: got %0d@%0d want %0d@%0d", end_peak, end_peak_idx, want_peak, want_idx);
    end
  endtask

  task automatic test_rst_mid();
    int dones, bad;
    @(posedge i_clk); #1;
    i_delay = 16'd2; i_count = 16'd300; i_decim = 8'd0; i_trig = 1'b1; i_sample_vld = 1'b0;
    @(posedge i_clk); #1;
    i_trig = 1'b0;
    repeat (6) begin
      @(posedge i_clk); #1;
      i_sample_vld = 1'b1; i_sample = BW'($urandom);
    end
    n_cmp++; if (o_ad_open !== 1'b1 || o_clamp !== 1'b1) begin n_err++; $display("FAIL rst_precond: got open=%b clamp=%b want 1 1", o_ad_open, o_clamp); end
    #3 i_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_ad_open, o_busy, o_rd_vld, o_done, o_clamp, o_miss, o_rd_data, o_peak, o_peak_idx}
        !== '0) begin
      n_err++;
      $display("FAIL rst_async: got open=%b busy=%b clamp=%b want all 0", o_ad_open, o_busy, o_clamp);
    end
    i_sample_vld = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk) i_rst_n = 1'b1;
    dones = 0;
    repeat (4) begin @(posedge i_clk); #1; if (o_done || o_busy) dones++; end
    n_cmp++; if (dones != 0) begin n_err++; $display("FAIL rst_no_done: got %0d active cycles want 0", dones); end
    do_capture(1, 6, 1, 1, 0, 1, 0);
    bad = 0;
    foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) bad++;
    n_cmp++; if (timeout || got_q.size() != 6 || bad != 0) begin n_err++; $display("FAIL rst_recapture: got %0d beats %0d wrong want 6 0", got_q.size(), bad); end
    n_cmp++; if (done_pulses != 1 || end_clamp !== 1'b0) begin n_err++; $display("FAIL rst_recap_status: got done=%0d clamp=%b want 1 0", done_pulses, end_clamp); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_decim();
    test_clamp_and_empty();
    test_stall_miss();
    test_peak();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
